// File: rtl/keypad_scanner.sv
//==============================================================================
// keypad_scanner : 4x4 matrix keypad column scanner with press/release debounce
// Revision 1.0
//==============================================================================
`default_nettype none

module keypad_scanner #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_n,
  output logic [3:0] cols_n,
  output logic [3:0] key,
  output logic       key_valid
);

  localparam int CNT_MAX = ((SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES) - 1;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t           state, state_nx;
  logic [3:0]       sync_q, rs_n;
  logic [1:0]       col, col_nx;
  logic [1:0]       row, row_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       key_nx;
  logic             valid_nx;
  logic             row_low;
  logic             any_low;
  logic [1:0]       low_row;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 4'hF;
      rs_n   <= 4'hF;
    end else begin
      sync_q <= rows_n;
      rs_n   <= sync_q;
    end
  end

  assign row_low = ~rs_n[row];
  assign any_low = ~&rs_n;
  assign cols_n  = ~(4'b0001 << col);

  // Lowest-index low row wins when several keys share the sampled column.
  always_comb begin
    low_row = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!rs_n[i]) low_row = 2'(i);
    end
  end

  always_comb begin
    state_nx = state;
    col_nx   = col;
    row_nx   = row;
    cnt_nx   = cnt;
    key_nx   = key;
    valid_nx = 1'b0;
    case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_nx = '0;
          if (any_low) begin
            row_nx   = low_row;
            state_nx = DEBOUNCE;
          end else begin
            col_nx = col + 2'd1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (row_low) begin
          if (cnt == DB_LAST) begin
            key_nx   = key_code(row, col);
            valid_nx = 1'b1;
            cnt_nx   = '0;
            state_nx = HELD;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end else begin
          col_nx   = col + 2'd1;
          cnt_nx   = '0;
          state_nx = SCAN;
        end
      end
      HELD: begin
        if (!row_low) begin
          cnt_nx   = '0;
          state_nx = RELEASE;
        end
      end
      RELEASE: begin
        if (row_low) begin
          cnt_nx = '0;
        end else if (cnt == DB_LAST) begin
          col_nx   = col + 2'd1;
          cnt_nx   = '0;
          state_nx = SCAN;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      col       <= 2'd0;
      row       <= 2'd0;
      cnt       <= '0;
      key       <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      col       <= col_nx;
      row       <= row_nx;
      cnt       <= cnt_nx;
      key       <= key_nx;
      key_valid <= valid_nx;
    end
  end

endmodule

`default_nettype wire
